// File: rtl/sudoku_pkg.sv
// Shared types and constants for the 4x4 sudoku board checker.
// Board is 16 cells of 4 bits, row-major, cell (0,0) in the top nibble.
package sudoku_pkg;

   localparam int CELL_W     = 4;
   localparam int BOARD_W    = 64;
   localparam int NUM_GROUPS = 12;

   localparam logic [3:0] GRP_ROW0 = 4'd0;
   localparam logic [3:0] GRP_COL0 = 4'd4;
   localparam logic [3:0] GRP_BOX0 = 4'd8;
   localparam logic [3:0] NO_ERR   = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } seqState_t;

   function automatic logic [CELL_W-1:0] cellAt(
      input logic [BOARD_W-1:0] b,
      input int                 r,
      input int                 c
   );
      return b[BOARD_W-1-16*r-CELL_W*c -: CELL_W];
   endfunction

endpackage

// File: rtl/board_check_sequencer_group_select.sv
// group_select: picks the four cells of group groupIdx from the board.
// Ports: board (64b), groupIdx (0-3 rows, 4-7 cols, 8-11 boxes),
// groupDigits (element k at [15-4k -: 4]).
module group_select
   import sudoku_pkg::*;
(
   input  logic [BOARD_W-1:0] board,
   input  logic [3:0]         groupIdx,
   output logic [15:0]        groupDigits
);

   always_comb begin
      groupDigits = '0;
      for (int k = 0; k < 4; k++) begin
         unique case (1'b1)
            (groupIdx < GRP_COL0):
               groupDigits[15-4*k -: 4] =
                  cellAt(board, int'(groupIdx - GRP_ROW0), k);
            (groupIdx >= GRP_COL0 && groupIdx < GRP_BOX0):
               groupDigits[15-4*k -: 4] =
                  cellAt(board, k, int'(groupIdx - GRP_COL0));
            (groupIdx >= GRP_BOX0 && int'(groupIdx) < NUM_GROUPS):
               // box b: TL, TR, BL, BR walk of a 2x2 block
               groupDigits[15-4*k -: 4] = cellAt(board,
                  2*(int'(groupIdx - GRP_BOX0)/2) + k/2,
                  2*(int'(groupIdx - GRP_BOX0)%2) + k%2);
            default:
               groupDigits[15-4*k -: 4] = '0;
         endcase
      end
   end

endmodule

// File: rtl/group_checker.sv
// groupChecker: combinational test that four digits are a permutation
// of {1,2,3,4}. Ports: groupDigits (element k at [15-4k -: 4]), valid.
module groupChecker (
   input  logic [15:0] groupDigits,
   output logic        valid
);

   logic [3:0] seen;
   logic       inRange;

   always_comb begin
      seen    = '0;
      inRange = 1'b1;
      for (int k = 0; k < 4; k++) begin
         unique case (groupDigits[15-4*k -: 4])
            4'd1:    seen[0] = 1'b1;
            4'd2:    seen[1] = 1'b1;
            4'd3:    seen[2] = 1'b1;
            4'd4:    seen[3] = 1'b1;
            default: inRange = 1'b0;
         endcase
      end
      // four in-range digits covering all four values => permutation
      valid = inRange & (&seen);
   end

endmodule

// File: rtl/board_check_sequencer.sv
// Scans a captured 4x4 sudoku board one group per cycle (rows, cols,
// boxes) through a shared groupChecker and reports solved/err stats.
// Ports: clk, rst_n, start, board -> busy, done, solved, err_count,
// first_err. Option: BOARD_CHECK_EARLY_EXIT_EN stops at first bad group.
module board_check_sequencer #(
   parameter bit AUTO_RESTART = 1'b0,
   parameter int NUM_GROUPS   = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] board,
   output logic        busy,
   output logic        done,
   output logic        solved,
   output logic [3:0]  err_count,
   output logic [3:0]  first_err
);

   import sudoku_pkg::*;

   localparam logic [3:0] LAST_GROUP = 4'(NUM_GROUPS - 1);

   seqState_t    state, nextState;
   logic [63:0]  boardReg;
   logic [3:0]   grpIdx;
   logic [3:0]   errCount;
   logic [3:0]   firstErr;
   logic         solvedReg;
   logic [15:0]  grpDigits;
   logic         grpValid;
   logic [3:0]   errNext;
   logic         earlyStop;
   logic         loadBoard;
   logic         clearStats;
   logic         scanning;
   logic         lastScan;

   group_select uSel (
      .board       (boardReg),
      .groupIdx    (grpIdx),
      .groupDigits (grpDigits)
   );

   groupChecker uChk (
      .groupDigits (grpDigits),
      .valid       (grpValid)
   );

   assign errNext = errCount + {3'b000, ~grpValid};

`ifdef BOARD_CHECK_EARLY_EXIT_EN
   assign earlyStop = ~grpValid;
`else
   assign earlyStop = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState  = state;
      busy       = 1'b0;
      done       = 1'b0;
      loadBoard  = 1'b0;
      clearStats = 1'b0;
      scanning   = 1'b0;
      lastScan   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               loadBoard  = 1'b1;
               clearStats = 1'b1;
               nextState  = ST_SCAN;
            end
         end
         ST_SCAN: begin
            busy     = 1'b1;
            scanning = 1'b1;
            if (grpIdx == LAST_GROUP || earlyStop) begin
               lastScan  = 1'b1;
               nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (AUTO_RESTART) begin
               clearStats = 1'b1;
               nextState  = ST_SCAN;
            end else begin
               nextState = ST_IDLE;
            end
         end
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         boardReg  <= '0;
         grpIdx    <= '0;
         errCount  <= '0;
         firstErr  <= NO_ERR;
         solvedReg <= 1'b0;
      end else begin
         if (loadBoard) boardReg <= board;
         if (clearStats) begin
            grpIdx    <= '0;
            errCount  <= '0;
            firstErr  <= NO_ERR;
            solvedReg <= 1'b0;
         end else if (scanning) begin
            errCount <= errNext;
            if (!grpValid && firstErr == NO_ERR) firstErr <= grpIdx;
            if (lastScan) begin
               grpIdx    <= '0;
               solvedReg <= (errNext == 4'd0);
            end else begin
               grpIdx <= grpIdx + 4'd1;
            end
         end
      end
   end

   assign solved    = solvedReg;
   assign err_count = errCount;
   assign first_err = firstErr;

endmodule

// File: tb/tb_board_check_sequencer.sv
// Self-checking bench for board_check_sequencer: directed boards plus
// random boards compared against a behavioural sudoku-rule model.
module tb_board_check_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [63:0] board;
   logic        busy;
   logic        done;
   logic        solved;
   logic [3:0]  err_count;
   logic [3:0]  first_err;

   int checks = 0;
   int fails  = 0;

   localparam logic [63:0] SOLVED_B = 64'h1234_3412_2143_4321;

   board_check_sequencer #(
      .AUTO_RESTART (1'b0),
      .NUM_GROUPS   (12)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .board     (board),
      .busy      (busy),
      .done      (done),
      .solved    (solved),
      .err_count (err_count),
      .first_err (first_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cellOf(input logic [63:0] b, input int r,
                                 input int c);
      logic [63:0] s;
      s = b >> (60 - 16*r - 4*c);
      return int'(s[3:0]);
   endfunction

   // Apply sudoku rules: a group is good iff each of 1..4 appears once.
   function automatic void model(input logic [63:0] b, output int ec,
                                 output int fe, output int lat);
      int cells [4];
      int cnt [5];
      bit ok;
      ec = 0;
      fe = 15;
      lat = 13;
      for (int g = 0; g < 12; g++) begin
         for (int k = 0; k < 4; k++) begin
            if (g < 4)      cells[k] = cellOf(b, g, k);
            else if (g < 8) cells[k] = cellOf(b, k, g - 4);
            else            cells[k] = cellOf(b,
                               ((g - 8) / 2) * 2 + k / 2,
                               ((g - 8) % 2) * 2 + k % 2);
         end
         for (int v = 0; v < 5; v++) cnt[v] = 0;
         for (int k = 0; k < 4; k++) cnt[cells[k]]++;
         ok = (cnt[1] == 1) && (cnt[2] == 1) &&
              (cnt[3] == 1) && (cnt[4] == 1);
         if (!ok) begin
            ec++;
            if (fe == 15) fe = g;
`ifdef BOARD_CHECK_EARLY_EXIT_EN
            lat = g + 2;
            return;
`endif
         end
      end
   endfunction

   task automatic run_check(input logic [63:0] b, input bit holdStart,
                            input int tail, input string tag);
      int ec, fe, lat, cyc, pulses;
      model(b, ec, fe, lat);
      @(negedge clk);
      board = b;
      start = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      if (!holdStart) start = 1'b0;
      board = ~b;
      checks++;
      if (busy !== 1'b1 || solved !== 1'b0) begin
         fails++;
         $display("FAIL %s_busy: busy=%b solved=%b want busy=1 solved=0",
                  tag, busy, solved);
      end
      while (done !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      checks++;
      if (cyc != lat) begin
         fails++;
         $display("FAIL %s_latency: done at T+%0d want T+%0d",
                  tag, cyc, lat);
      end
      checks++;
      if (err_count !== 4'(ec) || first_err !== 4'(fe) ||
          solved !== (ec == 0) || busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_result: err=%0d first=%h solved=%b busy=%b want err=%0d first=%h solved=%b busy=0",
                  tag, err_count, first_err, solved, busy, ec, fe, ec == 0);
      end
      pulses = 1;
      for (int i = 0; i < tail; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      if (tail > 0) begin
         checks++;
         if (pulses != 1 || solved !== (ec == 0)) begin
            fails++;
            $display("FAIL %s_after: pulses=%0d solved=%b want 1 pulse solved=%b",
                     tag, pulses, solved, ec == 0);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      board = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || solved !== 1'b0 ||
          err_count !== 4'd0 || first_err !== 4'hF) begin
         fails++;
         $display("FAIL reset: busy=%b done=%b solved=%b err=%0d first=%h want 0 0 0 0 f",
                  busy, done, solved, err_count, first_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_check(SOLVED_B, 1'b0, 4, "solved");
      run_check(64'h0, 1'b0, 4, "empty");
      run_check(64'h1234_3412_2143_4322, 1'b0, 4, "single_bad");
   endtask

   task automatic test_start_held();
      run_check(64'h2134_3412_2143_4321, 1'b1, 20, "cols_broken");
   endtask

   task automatic test_async_reset();
      int pulses;
      @(negedge clk);
      board = 64'h0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || solved !== 1'b0 ||
          err_count !== 4'd0 || first_err !== 4'hF) begin
         fails++;
         $display("FAIL midscan_reset: busy=%b done=%b solved=%b err=%0d first=%h want 0 0 0 0 f",
                  busy, done, solved, err_count, first_err);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_no_done: pulses=%0d busy=%b want 0 0",
                  pulses, busy);
      end
      run_check(SOLVED_B, 1'b0, 2, "after_reset");
   endtask

   task automatic test_random();
      logic [63:0] b;
      int r, c;
      for (int n = 0; n < 16; n++) begin
         if (n % 2 == 0) begin
            b = SOLVED_B;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            b[63-16*r-4*c -: 4] = 4'($urandom_range(0, 4));
         end else begin
            for (int i = 0; i < 16; i++)
               b[63-4*i -: 4] = 4'($urandom_range(0, 4));
         end
         run_check(b, 1'b0, 1, "random");
      end
   endtask

   task automatic test_back_to_back();
      run_check(64'h4321_2143_3412_1234, 1'b0, 1, "b2b_a");
      run_check(64'h1111_2222_3333_4444, 1'b0, 1, "b2b_b");
      run_check(SOLVED_B, 1'b0, 3, "b2b_c");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_held();
      test_async_reset();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
